// File: rtl/tag_array_nway_if.sv
// Bus bundle for tag_array_nway: lookup, refill and flush requests from the
// cache controller, plus the hit/refill results and the flush busy flag.
//   master : cache controller side (drives requests, reads results)
//   slave  : tag store side (reads requests, drives results)
interface tag_array_nway_if #(
    parameter int IBITS  = 3,
    parameter int WBITS  = 1,
    parameter int TWIDTH = 14
);
    logic              lk_valid;
    logic [IBITS-1:0]  lk_index;
    logic [TWIDTH-1:0] lk_tag;
    logic              fill_valid;
    logic [IBITS-1:0]  fill_index;
    logic [TWIDTH-1:0] fill_tag;
    logic              flush;
    logic              busy;
    logic              hit_valid;
    logic              hit;
    logic [WBITS-1:0]  hit_way;
    logic              fill_done;
    logic [WBITS-1:0]  fill_way;

    modport master (
        output lk_valid, lk_index, lk_tag,
        output fill_valid, fill_index, fill_tag, flush,
        input  busy, hit_valid, hit, hit_way, fill_done, fill_way
    );

    modport slave (
        input  lk_valid, lk_index, lk_tag,
        input  fill_valid, fill_index, fill_tag, flush,
        output busy, hit_valid, hit, hit_way, fill_done, fill_way
    );
endinterface

// File: rtl/tag_array_nway.sv
// N-way set-associative cache tag store.
// Holds a tag and valid bit per way per set, answers lookups with a registered
// hit/way one cycle later, picks refill ways (existing tag, else lowest
// invalid, else per-set round-robin victim) and clears all sets one per cycle
// on a flush.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of tag_array_nway_if (lookup/fill/flush in,
//             hit/fill results and busy out)
module tag_array_nway #(
    parameter int IBITS  = 3,
    parameter int WBITS  = 1,
    parameter int TWIDTH = 14
) (
    input  logic              clock,
    input  logic              reset_n,
    tag_array_nway_if.slave   bus
);
    localparam int SETS  = 1 << IBITS;
    localparam int NWAYS = 1 << WBITS;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                         state_q, state_d;
    logic [IBITS-1:0]               flush_idx_q, flush_idx_d;
    logic [SETS-1:0][NWAYS-1:0]     valid_q, valid_d;
    logic [SETS-1:0][WBITS-1:0]     rr_q, rr_d;
    logic [TWIDTH-1:0]              tag_q [SETS][NWAYS];
    logic                           hit_valid_q, hit_valid_d;
    logic                           hit_q, hit_d;
    logic [WBITS-1:0]               hit_way_q, hit_way_d;
    logic                           fill_done_q, fill_done_d;
    logic [WBITS-1:0]               fill_way_q, fill_way_d;

    logic                           idle;
    logic                           lk_go, fill_go;
    logic                           lk_hit;
    logic [WBITS-1:0]               lk_way;
    logic                           fill_match, fill_free;
    logic [WBITS-1:0]               fill_match_way, fill_free_way, fill_sel_way;

    // flush takes priority: requests on the accepting edge are dropped
    assign idle    = (state_q == IDLE);
    assign lk_go   = idle && bus.lk_valid   && !bus.flush;
    assign fill_go = idle && bus.fill_valid && !bus.flush;

    // Lookup compares against registered state, so a same-edge fill is not seen.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!lk_hit && valid_q[bus.lk_index][WBITS'(w)] &&
                tag_q[bus.lk_index][WBITS'(w)] == bus.lk_tag) begin
                lk_hit = 1'b1;
                lk_way = WBITS'(w);
            end
        end
    end

    // Refill way choice: matching valid way, else lowest invalid, else RR victim.
    always_comb begin
        fill_match     = 1'b0;
        fill_free      = 1'b0;
        fill_match_way = '0;
        fill_free_way  = '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
            if (!fill_match && valid_q[bus.fill_index][WBITS'(w)] &&
                tag_q[bus.fill_index][WBITS'(w)] == bus.fill_tag) begin
                fill_match     = 1'b1;
                fill_match_way = WBITS'(w);
            end
            if (!fill_free && !valid_q[bus.fill_index][WBITS'(w)]) begin
                fill_free     = 1'b1;
                fill_free_way = WBITS'(w);
            end
        end
        if (fill_match)
            fill_sel_way = fill_match_way;
        else if (fill_free)
            fill_sel_way = fill_free_way;
        else
            fill_sel_way = rr_q[bus.fill_index];
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        valid_d     = valid_q;
        rr_d        = rr_q;
        hit_valid_d = lk_go;
        hit_d       = hit_q;
        hit_way_d   = hit_way_q;
        fill_done_d = fill_go;
        fill_way_d  = fill_way_q;

        if (lk_go) begin
            hit_d     = lk_hit;
            hit_way_d = lk_way;
        end

        if (fill_go) begin
            valid_d[bus.fill_index][fill_sel_way] = 1'b1;
            if (!fill_match && !fill_free)
                rr_d[bus.fill_index] = rr_q[bus.fill_index] + 1'b1;
            fill_way_d = fill_sel_way;
        end

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end
            end
            FLUSH: begin
                valid_d[flush_idx_q] = '0;
                rr_d[flush_idx_q]    = '0;
                flush_idx_d          = flush_idx_q + 1'b1;
                if (flush_idx_q == IBITS'(SETS - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            flush_idx_q <= '0;
            valid_q     <= '0;
            rr_q        <= '0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
            fill_done_q <= 1'b0;
            fill_way_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            valid_q     <= valid_d;
            rr_q        <= rr_d;
            hit_valid_q <= hit_valid_d;
            hit_q       <= hit_d;
            hit_way_q   <= hit_way_d;
            fill_done_q <= fill_done_d;
            fill_way_q  <= fill_way_d;
        end
    end

    // Tag storage carries no reset; validity is tracked by valid_q alone.
    always_ff @(posedge clock) begin
        if (fill_go)
            tag_q[bus.fill_index][fill_sel_way] <= bus.fill_tag;
    end

    assign bus.busy      = (state_q == FLUSH);
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit       = hit_q;
    assign bus.hit_way   = hit_way_q;
    assign bus.fill_done = fill_done_q;
    assign bus.fill_way  = fill_way_q;
endmodule

// File: tb/tb_tag_array_nway.sv
// Self-checking bench for tag_array_nway (8 sets, 2 ways, 14-bit tags).
// Directed scenarios plus a randomized run checked against a behavioural
// model of the tag store kept as plain arrays.
module tb_tag_array_nway;
    localparam int IB    = 3;
    localparam int WB    = 1;
    localparam int TW    = 14;
    localparam int SETS  = 1 << IB;
    localparam int NWAYS = 1 << WB;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    tag_array_nway_if #(.IBITS(IB), .WBITS(WB), .TWIDTH(TW)) bus ();

    tag_array_nway #(.IBITS(IB), .WBITS(WB), .TWIDTH(TW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    bit              m_valid [SETS][NWAYS];
    logic [TW-1:0]   m_tag   [SETS][NWAYS];
    int              m_rr    [SETS];
    int              m_flush_left;
    logic            exp_busy, exp_hit_valid, exp_hit, exp_fill_done;
    logic [WB-1:0]   exp_hit_way, exp_fill_way;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_flush_left  = 0;
        exp_busy      = 1'b0;
        exp_hit_valid = 1'b0;
        exp_hit       = 1'b0;
        exp_hit_way   = '0;
        exp_fill_done = 1'b0;
        exp_fill_way  = '0;
    endtask

    // Apply one clock edge's worth of behaviour to the model using current inputs.
    task automatic model_edge();
        bit did_lk = 0, did_fill = 0;
        int way;
        if (m_flush_left > 0) begin
            for (int w = 0; w < NWAYS; w++) m_valid[SETS - m_flush_left][w] = 1'b0;
            m_rr[SETS - m_flush_left] = 0;
            m_flush_left--;
        end else if (bus.flush) begin
            m_flush_left = SETS;
        end else begin
            if (bus.lk_valid) begin
                did_lk = 1;
                exp_hit = 1'b0;
                exp_hit_way = '0;
                for (int w = NWAYS - 1; w >= 0; w--)
                    if (m_valid[bus.lk_index][w] && m_tag[bus.lk_index][w] == bus.lk_tag) begin
                        exp_hit = 1'b1;
                        exp_hit_way = WB'(w);
                    end
            end
            if (bus.fill_valid) begin
                did_fill = 1;
                way = -1;
                for (int w = 0; w < NWAYS && way < 0; w++)
                    if (m_valid[bus.fill_index][w] && m_tag[bus.fill_index][w] == bus.fill_tag) way = w;
                for (int w = 0; w < NWAYS && way < 0; w++)
                    if (!m_valid[bus.fill_index][w]) way = w;
                if (way < 0) begin
                    way = m_rr[bus.fill_index];
                    m_rr[bus.fill_index] = (m_rr[bus.fill_index] + 1) % NWAYS;
                end
                m_valid[bus.fill_index][way] = 1'b1;
                m_tag[bus.fill_index][way]   = bus.fill_tag;
                exp_fill_way = WB'(way);
            end
        end
        exp_hit_valid = did_lk;
        exp_fill_done = did_fill;
        exp_busy      = (m_flush_left > 0);
    endtask

    task automatic clear_inputs();
        bus.lk_valid   = 1'b0;
        bus.lk_index   = '0;
        bus.lk_tag     = '0;
        bus.fill_valid = 1'b0;
        bus.fill_index = '0;
        bus.fill_tag   = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic do_lookup(input int idx, input int tag);
        bus.lk_valid = 1'b1; bus.lk_index = IB'(idx); bus.lk_tag = TW'(tag);
        tick();
        clear_inputs();
    endtask

    task automatic do_fill(input int idx, input int tag);
        bus.fill_valid = 1'b1; bus.fill_index = IB'(idx); bus.fill_tag = TW'(tag);
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        apply_reset();
        outs = {bus.busy, bus.hit_valid, bus.hit, bus.fill_done, 3'b000, bus.hit_way ^ bus.fill_way};
        tests_run++;
        if (outs !== 8'h00 || bus.hit_way !== 1'b0 || bus.fill_way !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %b hw=%b fw=%b exp all zero", outs, bus.hit_way, bus.fill_way);
        end
        do_lookup(3, 'h0AB);
        tests_run++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0 || bus.hit_way !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_lookup_miss got hv=%b hit=%b way=%b exp hv=1 hit=0 way=0",
                     bus.hit_valid, bus.hit, bus.hit_way);
        end
        tick();
        tests_run++;
        if (bus.hit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hit_valid_idle got %b exp 0", bus.hit_valid);
        end
    endtask

    task automatic test_fill_hit();
        do_fill(3, 'h0AB);
        tests_run++;
        if (bus.fill_done !== 1'b1 || bus.fill_way !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_first got done=%b way=%b exp done=1 way=0", bus.fill_done, bus.fill_way);
        end
        do_lookup(3, 'h0AB);
        tests_run++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_way !== 1'b0) begin
            tests_failed++;
            $display("FAIL lookup_after_fill got hv=%b hit=%b way=%b exp 1 1 0",
                     bus.hit_valid, bus.hit, bus.hit_way);
        end
    endtask

    task automatic test_round_robin();
        int tags [4] = '{'h0AB, 'h111, 'h222, 'h333};
        int ways [4] = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            do_fill(3, tags[i]);
            tests_run++;
            if (bus.fill_done !== 1'b1 || bus.fill_way !== WB'(ways[i])) begin
                tests_failed++;
                $display("FAIL rr_fill%0d got done=%b way=%0d exp done=1 way=%0d",
                         i, bus.fill_done, bus.fill_way, ways[i]);
            end
        end
        do_lookup(3, 'h0AB);
        tests_run++;
        if (bus.hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_evicted got hit=%b exp 0", bus.hit);
        end
        do_lookup(3, 'h333);
        tests_run++;
        if (bus.hit !== 1'b1 || bus.hit_way !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_latest got hit=%b way=%b exp hit=1 way=1", bus.hit, bus.hit_way);
        end
    endtask

    task automatic test_dup_and_same_edge();
        for (int i = 0; i < 2; i++) begin
            do_fill(5, 'h010);
            tests_run++;
            if (bus.fill_way !== 1'b0) begin
                tests_failed++;
                $display("FAIL dup_fill%0d got way=%b exp 0", i, bus.fill_way);
            end
        end
        bus.lk_valid = 1'b1; bus.lk_index = 3'd5; bus.lk_tag = 14'h020;
        bus.fill_valid = 1'b1; bus.fill_index = 3'd5; bus.fill_tag = 14'h020;
        tick();
        clear_inputs();
        tests_run++;
        if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0 || bus.fill_way !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_edge got hv=%b hit=%b fill_way=%b exp hv=1 hit=0 fill_way=1",
                     bus.hit_valid, bus.hit, bus.fill_way);
        end
        do_lookup(5, 'h020);
        tests_run++;
        if (bus.hit !== 1'b1 || bus.hit_way !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_same_edge got hit=%b way=%b exp hit=1 way=1", bus.hit, bus.hit_way);
        end
    endtask

    task automatic test_flush();
        int n_busy = 0;
        for (int s = 0; s < SETS; s++) do_fill(s, 'h100 + s);
        tests_run++;
        if (bus.fill_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_before_flush got done=%b exp 1", bus.fill_done);
        end
        // lookup and fill on the flush edge are dropped
        bus.flush = 1'b1;
        bus.lk_valid = 1'b1; bus.lk_index = 3'd0; bus.lk_tag = 14'h100;
        bus.fill_valid = 1'b1; bus.fill_index = 3'd1; bus.fill_tag = 14'h3FF;
        tick();
        clear_inputs();
        tests_run++;
        if (bus.busy !== 1'b1 || bus.hit_valid !== 1'b0 || bus.fill_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_start got busy=%b hv=%b fd=%b exp busy=1 hv=0 fd=0",
                     bus.busy, bus.hit_valid, bus.fill_done);
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.busy !== 1'b1) break;
            n_busy++;
            bus.lk_valid = 1'b1; bus.lk_index = IB'(i); bus.lk_tag = TW'('h100 + i);
            tick();
            clear_inputs();
            tests_run++;
            if (bus.hit_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL lookup_while_busy cycle %0d got hv=%b exp 0", i, bus.hit_valid);
            end
        end
        tests_run++;
        if (n_busy != SETS || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_length got %0d busy cycles (busy now %b) exp %0d", n_busy, bus.busy, SETS);
        end
        for (int s = 0; s < SETS; s++) begin
            do_lookup(s, 'h100 + s);
            tests_run++;
            if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_flush_miss set %0d got hv=%b hit=%b exp hv=1 hit=0", s, bus.hit_valid, bus.hit);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        for (int s = 0; s < SETS; s++) begin
            do_fill(s, 'h200 + s);
            do_fill(s, 'h280 + s);
        end
        bus.flush = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hit_valid !== 1'b0 || bus.fill_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got busy=%b hv=%b fd=%b exp all 0", bus.busy, bus.hit_valid, bus.fill_done);
        end
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            do_lookup(s, 'h280 + s);
            tests_run++;
            if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_miss set %0d got hv=%b hit=%b exp hv=1 hit=0", s, bus.hit_valid, bus.hit);
            end
        end
        do_fill(7, 'h280);
        tests_run++;
        if (bus.fill_way !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_fill got way=%b busy=%b exp way=0 busy=0", bus.fill_way, bus.busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.lk_valid   = ($urandom_range(0, 3) != 0);
            bus.lk_index   = IB'($urandom_range(0, SETS - 1));
            bus.lk_tag     = TW'($urandom_range(0, 3) * 'h101 + 5);
            bus.fill_valid = ($urandom_range(0, 1) != 0);
            bus.fill_index = IB'($urandom_range(0, SETS - 1));
            bus.fill_tag   = TW'($urandom_range(0, 3) * 'h101 + 5);
            bus.flush      = ($urandom_range(0, 59) == 0);
            tick();
            tests_run++;
            if (bus.busy !== exp_busy || bus.hit_valid !== exp_hit_valid ||
                bus.hit !== exp_hit || bus.hit_way !== exp_hit_way ||
                bus.fill_done !== exp_fill_done ||
                (exp_fill_done && bus.fill_way !== exp_fill_way)) begin
                tests_failed++;
                $display("FAIL random cycle %0d got busy=%b hv=%b hit=%b hw=%b fd=%b fw=%b exp busy=%b hv=%b hit=%b hw=%b fd=%b fw=%b",
                         i, bus.busy, bus.hit_valid, bus.hit, bus.hit_way, bus.fill_done, bus.fill_way,
                         exp_busy, exp_hit_valid, exp_hit, exp_hit_way, exp_fill_done, exp_fill_way);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fill_hit();
        test_round_robin();
        test_dup_and_same_edge();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
